// File: rtl/udp_pkg.sv
// ============================================================================
// Module   : udp_pkg
// Brief    : Shared types, header offsets and helpers for the UDP port router.
// Revision : 1.0
// ============================================================================
`default_nettype none

package udp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    DROP    = 3'd3,
    ABORT   = 3'd4
  } udp_state_t;

  localparam int         UDP_HDR_LEN = 8;
  localparam int         UDP_PORT_W  = 16;
  localparam logic [2:0] UDP_DST_HI  = 3'd2;
  localparam logic [2:0] UDP_DST_LO  = 3'd3;
  localparam logic [2:0] UDP_LEN_HI  = 3'd4;
  localparam logic [2:0] UDP_LEN_LO  = 3'd5;
  localparam logic [2:0] UDP_HDR_END = 3'd7;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udp_port_match.sv
// ============================================================================
// Module   : udp_port_match
// Brief    : Combinational priority matcher; lowest enabled channel wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module udp_port_match
  import udp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH*UDP_PORT_W-1:0] cfg_port,
  input  logic [NUM_CH-1:0]            cfg_valid,
  input  logic [UDP_PORT_W-1:0]        port,
  output logic                         hit,
  output logic [IDX_W-1:0]             idx
);

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_valid[i] && (cfg_port[UDP_PORT_W*i +: UDP_PORT_W] == port)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/udp_port_router.sv
// ============================================================================
// Module   : udp_port_router
// Brief    : Strips the UDP header and steers payload to a port-matched channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module udp_port_router
  import udp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_dout,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  input  logic [NUM_CH*16-1:0] cfg_port,
  input  logic [NUM_CH-1:0]    cfg_valid,
  output logic [7:0]           out_dout,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_err,
  output logic [NUM_CH-1:0]    out_wr_en,
  input  logic [NUM_CH-1:0]    out_full,
  output logic [CNT_W-1:0]     stat_rx,
  output logic [CNT_W-1:0]     stat_drop,
  output logic [CNT_W-1:0]     stat_len_err
);

  localparam int               IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0]      HDR_LEN = 16'(UDP_HDR_LEN);

  udp_state_t       state_q, state_d;
  logic [2:0]       hdr_idx_q, hdr_idx_d;
  logic [7:0]       port_hi_q, port_hi_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] ch_q, ch_d;
  logic             hit_q, hit_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] stat_rx_q, stat_drop_q, stat_len_err_q;

  logic             w_rd, w_wr, w_sof, w_eof, w_err, w_filler;
  logic             w_inc_rx, w_inc_drop, w_inc_len;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic [15:0]      w_cnt_next;
  logic [NUM_CH-1:0] w_wr_en;

  udp_port_match #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_match (
    .cfg_port  (cfg_port),
    .cfg_valid (cfg_valid),
    .port      ({port_hi_q, in_dout}),
    .hit       (w_hit),
    .idx       (w_idx)
  );

  assign w_cnt_next = sat_inc16(cnt_q);

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    port_hi_d  = port_hi_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    hit_d      = hit_q;
    first_d    = first_q;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_sof      = 1'b0;
    w_eof      = 1'b0;
    w_err      = 1'b0;
    w_filler   = 1'b0;
    w_inc_rx   = 1'b0;
    w_inc_drop = 1'b0;
    w_inc_len  = 1'b0;

    case (state_q)
      IDLE, DROP: begin
        w_rd = !in_empty;
        if (w_rd) begin
          if (in_sof) begin
            if (in_eof) begin
              w_inc_len = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d   = HDR;
              hdr_idx_d = 3'd1;
              cnt_d     = 16'd1;
            end
          end else if (in_eof && state_q == DROP) begin
            state_d = IDLE;
          end
        end
      end

      HDR: begin
        w_rd = !in_empty;
        if (w_rd) begin
          if (in_sof) begin
            w_inc_len = 1'b1;
            hdr_idx_d = 3'd1;
            cnt_d     = 16'd1;
            if (in_eof) state_d = IDLE;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
            cnt_d     = w_cnt_next;
            case (hdr_idx_q)
              UDP_DST_HI: port_hi_d   = in_dout;
              UDP_DST_LO: begin
                hit_d = w_hit;
                ch_d  = w_idx;
              end
              UDP_LEN_HI: len_d[15:8] = in_dout;
              UDP_LEN_LO: len_d[7:0]  = in_dout;
              default: ;
            endcase
            if (hdr_idx_q == UDP_HDR_END) begin
              // Length errors take priority over port misses.
              if (len_q < HDR_LEN) begin
                w_inc_len = 1'b1;
                state_d   = in_eof ? IDLE : DROP;
              end else if (!hit_q) begin
                w_inc_drop = 1'b1;
                state_d    = in_eof ? IDLE : DROP;
              end else if (in_eof) begin
                w_inc_rx  = 1'b1;
                w_inc_len = (len_q != HDR_LEN);
                state_d   = IDLE;
              end else begin
                first_d = 1'b1;
                state_d = PAYLOAD;
              end
            end else if (in_eof) begin
              w_inc_len = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end

      PAYLOAD: begin
        if (!in_empty && in_sof) begin
          state_d = ABORT;
        end else begin
          w_rd = !in_empty && !out_full[ch_q];
          if (w_rd) begin
            w_wr    = 1'b1;
            w_sof   = first_q;
            first_d = 1'b0;
            cnt_d   = w_cnt_next;
            if (in_eof) begin
              w_eof     = 1'b1;
              w_err     = (w_cnt_next != len_q);
              w_inc_rx  = 1'b1;
              w_inc_len = (w_cnt_next != len_q);
              state_d   = IDLE;
            end
          end
        end
      end

      ABORT: begin
        // Terminate the downstream frame; the new sof stays at the FIFO head.
        if (!out_full[ch_q]) begin
          w_wr      = 1'b1;
          w_filler  = 1'b1;
          w_sof     = first_q;
          w_eof     = 1'b1;
          w_err     = 1'b1;
          w_inc_len = 1'b1;
          first_d   = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_en[i] = w_wr && (ch_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      hdr_idx_q      <= 3'd0;
      port_hi_q      <= 8'h00;
      len_q          <= 16'h0000;
      cnt_q          <= 16'h0000;
      ch_q           <= '0;
      hit_q          <= 1'b0;
      first_q        <= 1'b0;
      stat_rx_q      <= '0;
      stat_drop_q    <= '0;
      stat_len_err_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      port_hi_q <= port_hi_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      hit_q     <= hit_d;
      first_q   <= first_d;
      if (w_inc_rx && stat_rx_q != CNT_MAX)
        stat_rx_q <= stat_rx_q + CNT_W'(1);
      if (w_inc_drop && stat_drop_q != CNT_MAX)
        stat_drop_q <= stat_drop_q + CNT_W'(1);
      if (w_inc_len && stat_len_err_q != CNT_MAX)
        stat_len_err_q <= stat_len_err_q + CNT_W'(1);
    end
  end

  assign in_rd_en     = !reset && w_rd;
  assign out_wr_en    = reset ? '0 : w_wr_en;
  assign out_dout     = (reset || w_filler) ? 8'h00 : in_dout;
  assign out_sof      = !reset && w_sof;
  assign out_eof      = !reset && w_eof;
  assign out_err      = !reset && w_err;
  assign stat_rx      = stat_rx_q;
  assign stat_drop    = stat_drop_q;
  assign stat_len_err = stat_len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_udp_port_router.sv
// ============================================================================
// Module   : tb_udp_port_router
// Brief    : Directed self-checking bench for udp_port_router.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_udp_port_router;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [7:0]           in_dout;
  logic                 in_sof, in_eof, in_empty, in_rd_en;
  logic [NUM_CH*16-1:0] cfg_port;
  logic [NUM_CH-1:0]    cfg_valid;
  logic [7:0]           out_dout;
  logic                 out_sof, out_eof, out_err;
  logic [NUM_CH-1:0]    out_wr_en, out_full;
  logic [CNT_W-1:0]     stat_rx, stat_drop, stat_len_err;

  always #5 clock = ~clock;

  udp_port_router #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_dout      (in_dout),
    .in_sof       (in_sof),
    .in_eof       (in_eof),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .cfg_port     (cfg_port),
    .cfg_valid    (cfg_valid),
    .out_dout     (out_dout),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_err      (out_err),
    .out_wr_en    (out_wr_en),
    .out_full     (out_full),
    .stat_rx      (stat_rx),
    .stat_drop    (stat_drop),
    .stat_len_err (stat_len_err)
  );

  typedef struct packed {logic sof; logic eof; logic [7:0] d;} ib_t;
  typedef struct packed {logic [NUM_CH-1:0] en; logic [7:0] d; logic s; logic e; logic r;} wr_t;

  ib_t  q_in[$];
  wr_t  wlog[$];
  logic rdlog[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // One clock: present the FIFO head, sample mid-cycle, pop on the edge.
  task automatic tick(input logic [NUM_CH-1:0] full);
    logic rd;
    wr_t  w;
    out_full = full;
    if (q_in.size() == 0) begin
      in_empty = 1'b1; in_dout = 8'h00; in_sof = 1'b0; in_eof = 1'b0;
    end else begin
      in_empty = 1'b0; in_dout = q_in[0].d; in_sof = q_in[0].sof; in_eof = q_in[0].eof;
    end
    #1;
    rd = in_rd_en;
    rdlog.push_back(rd);
    if (out_wr_en != '0) begin
      w = {out_wr_en, out_dout, out_sof, out_eof, out_err};
      wlog.push_back(w);
    end
    @(posedge clock);
    if (rd && q_in.size() > 0) void'(q_in.pop_front());
    @(negedge clock);
  endtask

  task automatic push_dgram(input logic [15:0] dst, input logic [15:0] len,
                            input logic [63:0] pl, input int n, input logic with_eof);
    logic [7:0] hdr[8];
    ib_t        b;
    int         total;
    hdr[0] = 8'h11; hdr[1] = 8'h11; hdr[2] = dst[15:8]; hdr[3] = dst[7:0];
    hdr[4] = len[15:8]; hdr[5] = len[7:0]; hdr[6] = 8'h00; hdr[7] = 8'h00;
    total = 8 + n;
    for (int k = 0; k < total; k++) begin
      b.d   = (k < 8) ? hdr[k] : pl[63-8*(k-8) -: 8];
      b.sof = (k == 0);
      b.eof = (k == total - 1) && with_eof;
      q_in.push_back(b);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q_in.delete();
    tick('0);
    tick('0);
    reset = 1'b0;
    wlog.delete();
    rdlog.delete();
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (q_in.size() > 0 && k < max) begin
      tick('0);
      k++;
    end
    n_tests++;
    if (q_in.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes left, required 0", q_in.size());
    end
    tick('0);
    tick('0);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_empty = 1'b0; in_dout = 8'h5A; in_sof = 1'b1; in_eof = 1'b1; out_full = '0;
    @(posedge clock); @(negedge clock); #1;
    n_tests++; if (in_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", in_rd_en); end
    n_tests++; if (out_wr_en !== '0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", out_wr_en); end
    n_tests++; if (out_dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h want 00", out_dout); end
    n_tests++; if ({out_sof, out_eof, out_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {out_sof, out_eof, out_err}); end
    n_tests++; if ({stat_rx, stat_drop, stat_len_err} !== '0) begin n_fail++; $display("FAIL rst_counters: got %h/%h/%h want 0", stat_rx, stat_drop, stat_len_err); end
    @(negedge clock);
    in_empty = 1'b1;
    reset = 1'b0;
  endtask

  task automatic test_route();
    logic [31:0] exp = 32'hAABBCCDD;
    do_reset();
    push_dgram(16'h5678, 16'h000C, {32'hAABBCCDD, 32'h0}, 4, 1'b1);
    repeat (12) tick('0);
    n_tests++; if (q_in.size() != 0) begin n_fail++; $display("FAIL route_12cyc: %0d bytes left want 0", q_in.size()); end
    n_tests++; if (wlog.size() != 4) begin n_fail++; $display("FAIL route_nwr: got %0d want 4", wlog.size()); end
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      n_tests++;
      if (wlog[k] !== {4'b0010, exp[31-8*k -: 8], k == 0, k == 3, 1'b0}) begin
        n_fail++; $display("FAIL route_byte%0d: got %h want %h", k, wlog[k], {4'b0010, exp[31-8*k -: 8], k == 0, k == 3, 1'b0});
      end
    end
    n_tests++; if (stat_rx !== 16'd1 || stat_len_err !== 16'd0) begin n_fail++; $display("FAIL route_stats: rx %0d len_err %0d want 1/0", stat_rx, stat_len_err); end
  endtask

  task automatic test_drop();
    do_reset();
    push_dgram(16'h9999, 16'h000C, {32'hAABBCCDD, 32'h0}, 4, 1'b1);
    repeat (12) tick('0);
    n_tests++; if (q_in.size() != 0) begin n_fail++; $display("FAIL drop_12cyc: %0d bytes left want 0", q_in.size()); end
    n_tests++; if (wlog.size() != 0) begin n_fail++; $display("FAIL drop_nwr: got %0d want 0", wlog.size()); end
    n_tests++; if (stat_drop !== 16'd1 || stat_rx !== 16'd0) begin n_fail++; $display("FAIL drop_stats: drop %0d rx %0d want 1/0", stat_drop, stat_rx); end
  endtask

  task automatic test_len_mismatch();
    do_reset();
    push_dgram(16'h5678, 16'h0010, {32'hAABBCCDD, 32'h0}, 4, 1'b1);
    drain(40);
    n_tests++;
    if (wlog.size() != 4) begin
      n_fail++; $display("FAIL len_nwr: got %0d want 4", wlog.size());
    end else if (wlog[3] !== {4'b0010, 8'hDD, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL len_last: got %h want %h", wlog[3], {4'b0010, 8'hDD, 3'b011});
    end
    n_tests++; if (stat_len_err !== 16'd1 || stat_rx !== 16'd1) begin n_fail++; $display("FAIL len_stats: len_err %0d rx %0d want 1/1", stat_len_err, stat_rx); end
  endtask

  task automatic test_abort();
    logic [7:0] ed[7];
    logic [6:0] es, ee, er;
    ed = '{8'hAA, 8'hBB, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    es = 7'b1001000; ee = 7'b0010001; er = 7'b0010000;
    do_reset();
    push_dgram(16'h5678, 16'h000C, {16'hAABB, 48'h0}, 2, 1'b0);
    push_dgram(16'h5678, 16'h000C, {32'h11223344, 32'h0}, 4, 1'b1);
    drain(60);
    n_tests++; if (wlog.size() != 7) begin n_fail++; $display("FAIL abort_nwr: got %0d want 7", wlog.size()); end
    for (int k = 0; k < 7 && k < wlog.size(); k++) begin
      n_tests++;
      if (wlog[k] !== {4'b0010, ed[k], es[6-k], ee[6-k], er[6-k]}) begin
        n_fail++; $display("FAIL abort_wr%0d: got %h want %h", k, wlog[k], {4'b0010, ed[k], es[6-k], ee[6-k], er[6-k]});
      end
    end
    n_tests++; if (stat_len_err !== 16'd1 || stat_rx !== 16'd1) begin n_fail++; $display("FAIL abort_stats: len_err %0d rx %0d want 1/1", stat_len_err, stat_rx); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_dgram(16'h5678, 16'h0010, 64'h0102030405060708, 8, 1'b1);
    repeat (10) tick('0);
    repeat (5) tick(4'b0010);
    drain(40);
    for (int k = 10; k < 15; k++) begin
      n_tests++; if (rdlog[k] !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: rd_en %b want 0", k - 10, rdlog[k]); end
    end
    n_tests++; if (rdlog[9] !== 1'b1 || rdlog[15] !== 1'b1) begin n_fail++; $display("FAIL bp_edges: rd_en before %b after %b want 1/1", rdlog[9], rdlog[15]); end
    n_tests++; if (wlog.size() != 8) begin n_fail++; $display("FAIL bp_nwr: got %0d want 8", wlog.size()); end
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      n_tests++;
      if (wlog[k] !== {4'b0010, 8'(k + 1), k == 0, k == 7, 1'b0}) begin
        n_fail++; $display("FAIL bp_byte%0d: got %h want %h", k, wlog[k], {4'b0010, 8'(k + 1), k == 0, k == 7, 1'b0});
      end
    end
    n_tests++; if (stat_rx !== 16'd1 || stat_len_err !== 16'd0) begin n_fail++; $display("FAIL bp_stats: rx %0d len_err %0d want 1/0", stat_rx, stat_len_err); end
  endtask

  task automatic test_short_frames();
    ib_t b;
    do_reset();
    push_dgram(16'h5678, 16'h0008, 64'h0, 0, 1'b1);
    push_dgram(16'h5678, 16'h000C, 64'h0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      b.d = 8'h40 + 8'(k); b.sof = (k == 0); b.eof = (k == 3);
      q_in.push_back(b);
    end
    drain(40);
    n_tests++; if (wlog.size() != 0) begin n_fail++; $display("FAIL short_nwr: got %0d want 0", wlog.size()); end
    n_tests++; if (stat_rx !== 16'd2 || stat_len_err !== 16'd2 || stat_drop !== 16'd0) begin
      n_fail++; $display("FAIL short_stats: rx %0d len_err %0d drop %0d want 2/2/0", stat_rx, stat_len_err, stat_drop);
    end
  endtask

  task automatic test_priority_reset();
    do_reset();
    cfg_port  = {16'h0000, 16'h0050, 16'h5678, 16'h0050};
    cfg_valid = 4'b0111;
    push_dgram(16'h0050, 16'h000C, {32'hAABBCCDD, 32'h0}, 4, 1'b1);
    drain(40);
    n_tests++; if (wlog.size() != 4 || wlog[0].en !== 4'b0001 || wlog[3].en !== 4'b0001) begin
      n_fail++; $display("FAIL prio_ch: nwr %0d en %b want 4 writes to 0001", wlog.size(), (wlog.size() > 0) ? wlog[0].en : 4'b0000);
    end
    n_tests++; if (stat_rx !== 16'd1) begin n_fail++; $display("FAIL prio_rx: got %0d want 1", stat_rx); end
    push_dgram(16'h0050, 16'h000C, {32'hAABBCCDD, 32'h0}, 4, 1'b1);
    repeat (10) tick('0);
    reset = 1'b1;
    tick('0);
    tick('0);
    n_tests++; if (rdlog[rdlog.size()-1] !== 1'b0) begin n_fail++; $display("FAIL midrst_rd: got %b want 0", rdlog[rdlog.size()-1]); end
    n_tests++; if ({stat_rx, stat_drop, stat_len_err} !== '0) begin n_fail++; $display("FAIL midrst_cnt: got %h/%h/%h want 0", stat_rx, stat_drop, stat_len_err); end
    reset = 1'b0;
    q_in.delete();
    wlog.delete();
    push_dgram(16'h0050, 16'h000C, {32'h11223344, 32'h0}, 4, 1'b1);
    drain(40);
    n_tests++; if (wlog.size() != 4) begin
      n_fail++; $display("FAIL post_nwr: got %0d want 4", wlog.size());
    end else if (wlog[0] !== {4'b0001, 8'h11, 3'b100} || wlog[3] !== {4'b0001, 8'h44, 3'b010}) begin
      n_fail++; $display("FAIL post_frame: got %h..%h want %h..%h", wlog[0], wlog[3], {4'b0001, 8'h11, 3'b100}, {4'b0001, 8'h44, 3'b010});
    end
    n_tests++; if (stat_rx !== 16'd1) begin n_fail++; $display("FAIL post_rx: got %0d want 1", stat_rx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_empty  = 1'b1;
    in_dout   = 8'h00;
    in_sof    = 1'b0;
    in_eof    = 1'b0;
    out_full  = '0;
    cfg_port  = {16'h0000, 16'h0000, 16'h5678, 16'h1234};
    cfg_valid = 4'b0011;
    test_reset();
    test_route();
    test_drop();
    test_len_mismatch();
    test_abort();
    test_backpressure();
    test_short_frames();
    test_priority_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
